memoria_instrucciones_prog: RTL and testbench
=============================================

Name: memoria_instrucciones_prog

Overview:
- Parametrised instruction ROM/RAM for the pipeline IF stage, with a synchronous registered read.
- Adds three things over a fixed initial image:
  - a self-clearing fill on reset;
  - a run-time word-programming port with valid/ready handshake and auto-increment;
  - a stall-aware fetch port with an output valid.
- Sits between the PC register and the IF/ID pipeline register. The testbench or loader uses the programming port to deposit programs without recompiling.

Parameters:
- DATA_W, 32: instruction word width.
- ADDR_W, 10: fetch/program address width.
- DEPTH, 1024: number of words; must satisfy DEPTH <= 2**ADDR_W.
- FILL_WORD, 32'h00000000: value written to every word by the clear fill (HLT).

Ports:
- clk, in, 1: single clock; all state changes on posedge.
- reset_n, in, 1: reset is synchronous and active-low.
- fetch_en, in, 1: fetch request; 0 = IF stall.
- fetch_addr, in, ADDR_W: word address to fetch.
- instr, out, DATA_W: registered instruction word.
- instr_valid, out, 1: instr holds a word fetched after clear/program completed.
- prog_start, in, 1: one-cycle pulse that enters programming mode.
- prog_base, in, ADDR_W: start address, sampled with prog_start.
- prog_valid, in, 1: prog_data is offered.
- prog_data, in, DATA_W: word to write.
- prog_last, in, 1: qualifies the final word of a program burst.
- prog_ready, out, 1: block can accept a word this cycle.
- busy, out, 1: clear fill or programming in progress.
- prog_overflow, out, 1: sticky; programming address wrapped past DEPTH-1.

Behaviour:

Reset (reset_n=0 at a posedge):
- state <= CLEAR, clr_ptr <= 0.
- instr <= FILL_WORD, instr_valid <= 0.
- prog_ready <= 0, busy <= 1, prog_overflow <= 0.
- Applies from any state, including mid-CLEAR and mid-PROG; partial programs are discarded by the new fill.

State CLEAR:
- Writes mem[clr_ptr] <= FILL_WORD, one word per cycle, then clr_ptr++.
- After writing DEPTH-1, goes to RUN. The fill lasts exactly DEPTH cycles after reset release.
- fetch_en and prog_start are ignored; instr and instr_valid hold their reset values.

State RUN:
- busy=0, prog_ready=0.
- fetch_en=1 at edge N: instr <= mem[fetch_addr] and instr_valid <= 1 at edge N (one-cycle read latency).
- fetch_en=0: instr and instr_valid hold (stall).
- fetch_addr >= DEPTH: instr <= FILL_WORD, no error.
- prog_start=1: latch wr_ptr <= prog_base, clear prog_overflow, instr_valid <= 0, go to PROG.
- prog_start and fetch_en in the same cycle: prog_start wins and the fetch is dropped.

State PROG:
- busy=1, prog_ready=1, fetches ignored, instr holds, instr_valid=0.
- On prog_valid & prog_ready: mem[wr_ptr] <= prog_data.
  - If wr_ptr == DEPTH-1: wr_ptr <= 0 and prog_overflow <= 1.
  - Otherwise wr_ptr <= wr_ptr+1.
- prog_base >= DEPTH: wr_ptr starts at prog_base mod DEPTH.
- Accepted beat with prog_last=1: write it, return to RUN the next cycle.
- prog_last without prog_valid is ignored.
- prog_start while in PROG: re-latch prog_base with no write that cycle; prog_overflow is cleared.

Memory rules:
- Read-first: the registered read returns the pre-write value if the same address is written that cycle. This cannot occur across states, but the rule is stated for implementation.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset and clear: hold reset_n=0 for 3 cycles, release, DEPTH=16 -> busy=1 for exactly 16 cycles, then 0. The first fetch of addr 5 returns 32'h00000000 with instr_valid=1 one cycle later.
- Program and fetch: after clear, prog_start with prog_base=0, then beats 32'h3C0280FF, 32'h00210820 (second with prog_last) -> busy drops on the cycle after the last beat. Fetching addr 0 then addr 1 yields 32'h3C0280FF then 32'h00210820 on consecutive cycles.
- Stall: fetch addr 1, then fetch_en=0 for 4 cycles while fetch_addr toggles 2/3 -> instr stays 32'h00210820 and instr_valid stays 1 throughout.
- Wrap/overflow: DEPTH=16, prog_base=15, write words A, B, C (last) -> mem[15]=A, mem[0]=B, mem[1]=C, prog_overflow=1. A following prog_start clears it to 0.
- Out-of-range: DEPTH=16, ADDR_W=5, fetch addr 20 -> instr=FILL_WORD.
- Reset mid-program: assert reset_n=0 after 2 of 4 beats -> full CLEAR re-runs, and the previously written addresses read back FILL_WORD.

Source files
------------

// File: rtl/memoria_instrucciones_prog.sv
// -----------------------------------------------------------------------------
// memoria_instrucciones_prog
// Instruction memory for the IF stage with a registered (one-cycle) read.
// After every reset the whole array is filled with FILL_WORD, one word per
// cycle. A loader can deposit programs at run time through a valid/ready
// word port with an auto-incrementing write pointer. Fetches honour an IF
// stall and carry an output valid.
//
// Ports
//   clk            single clock, all state changes on posedge
//   reset_n        synchronous active-low reset
//   fetch_en       fetch request (0 = IF stall, instr/instr_valid hold)
//   fetch_addr     word address to fetch
//   instr          registered instruction word
//   instr_valid    instr holds a word fetched after clear/program completed
//   prog_start     one-cycle pulse entering programming mode
//   prog_base      programming start address, sampled with prog_start
//   prog_valid     prog_data is offered
//   prog_data      word to write
//   prog_last      marks the final word of a program burst
//   prog_ready     block accepts a word this cycle
//   busy           clear fill or programming in progress
//   prog_overflow  sticky, programming pointer wrapped past DEPTH-1
// -----------------------------------------------------------------------------
module memoria_instrucciones_prog #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 10,
    parameter int unsigned       DEPTH     = 1024,
    parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              prog_start,
    input  logic [ADDR_W-1:0] prog_base,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_last,
    output logic              prog_ready,
    output logic              busy,
    output logic              prog_overflow
);

    // Index width of the storage array; one extra address bit lets DEPTH be
    // represented exactly even when DEPTH == 2**ADDR_W.
    localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned       AW1      = ADDR_W + 1;
    localparam logic [AW1-1:0]    DEPTH_A  = AW1'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_RUN   = 2'd1,
        S_PROG  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [IDX_W-1:0]    r_clr_ptr;
    logic [IDX_W-1:0]    w_clr_ptr_nxt;
    logic [IDX_W-1:0]    r_wr_ptr;
    logic [IDX_W-1:0]    w_wr_ptr_nxt;
    logic [DATA_W-1:0]   r_instr;
    logic [DATA_W-1:0]   w_instr_nxt;
    logic                r_instr_valid;
    logic                w_instr_valid_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_prog_ready;
    logic                w_prog_ready_nxt;
    logic                r_overflow;
    logic                w_overflow_nxt;

    logic                w_we;
    logic [IDX_W-1:0]    w_waddr;
    logic [DATA_W-1:0]   w_wdata;

    logic                w_fetch_in_range;
    logic [DATA_W-1:0]   w_rd_word;
    logic [IDX_W-1:0]    w_base_idx;
    logic                w_beat;

    // Read data before this edge's write lands, so same-address access is read-first.
    assign w_fetch_in_range = ({1'b0, fetch_addr} < DEPTH_A);
    assign w_rd_word        = w_fetch_in_range ? r_mem[fetch_addr[IDX_W-1:0]] : FILL_WORD;

    // Programming base folded into the array (prog_base mod DEPTH).
    assign w_base_idx = IDX_W'({1'b0, prog_base} % DEPTH_A);

    // Accepted program beat; a prog_start in the same cycle suppresses the write.
    assign w_beat = (r_state == S_PROG) & prog_valid & r_prog_ready & ~prog_start;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_ptr == LAST_IDX) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (prog_start) begin
                    w_state_nxt = S_PROG;
                end
            end
            S_PROG: begin
                if (w_beat && prog_last) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // Output / datapath next-value logic.
    always_comb begin
        w_clr_ptr_nxt     = r_clr_ptr;
        w_wr_ptr_nxt      = r_wr_ptr;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = r_instr_valid;
        w_overflow_nxt    = r_overflow;
        w_we              = 1'b0;
        w_waddr           = r_clr_ptr;
        w_wdata           = FILL_WORD;

        case (r_state)
            S_CLEAR: begin
                w_we          = 1'b1;
                w_waddr       = r_clr_ptr;
                w_wdata       = FILL_WORD;
                w_clr_ptr_nxt = r_clr_ptr + IDX_W'(1);
            end
            S_RUN: begin
                if (prog_start) begin
                    // Entering PROG drops any fetch issued in the same cycle.
                    w_wr_ptr_nxt      = w_base_idx;
                    w_overflow_nxt    = 1'b0;
                    w_instr_valid_nxt = 1'b0;
                end else if (fetch_en) begin
                    w_instr_nxt       = w_rd_word;
                    w_instr_valid_nxt = 1'b1;
                end
            end
            S_PROG: begin
                w_instr_valid_nxt = 1'b0;
                if (prog_start) begin
                    w_wr_ptr_nxt   = w_base_idx;
                    w_overflow_nxt = 1'b0;
                end else if (w_beat) begin
                    w_we    = 1'b1;
                    w_waddr = r_wr_ptr;
                    w_wdata = prog_data;
                    if (r_wr_ptr == LAST_IDX) begin
                        w_wr_ptr_nxt   = '0;
                        w_overflow_nxt = 1'b1;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_we = 1'b0;
            end
        endcase

        // Status outputs are registered copies of the mode being entered.
        w_busy_nxt       = (w_state_nxt != S_RUN);
        w_prog_ready_nxt = (w_state_nxt == S_PROG);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_clr_ptr     <= '0;
            r_wr_ptr      <= '0;
            r_instr       <= FILL_WORD;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b1;
            r_prog_ready  <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_clr_ptr     <= w_clr_ptr_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_busy        <= w_busy_nxt;
            r_prog_ready  <= w_prog_ready_nxt;
            r_overflow    <= w_overflow_nxt;
        end
    end

    // Storage array; no writes on a reset edge, the fill restarts afterwards.
    always_ff @(posedge clk) begin
        if (reset_n && w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign instr         = r_instr;
    assign instr_valid   = r_instr_valid;
    assign prog_ready    = r_prog_ready;
    assign busy          = r_busy;
    assign prog_overflow = r_overflow;

endmodule

// File: tb/tb_memoria_instrucciones_prog.sv
// -----------------------------------------------------------------------------
// tb_memoria_instrucciones_prog
// Drives directed scenarios followed by randomized traffic. A behavioural
// model (associative-array memory plus a mode variable) predicts every output
// each cycle; directed steps add literal expectations that pin the model.
// Inputs change on negedge, the model advances on posedge, outputs are
// compared on negedge.
// -----------------------------------------------------------------------------
module tb_memoria_instrucciones_prog;

    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 5;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] FILL   = 32'hF000_000F;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_en;
    logic [4:0]  fetch_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic        prog_start;
    logic [4:0]  prog_base;
    logic        prog_valid;
    logic [31:0] prog_data;
    logic        prog_last;
    logic        prog_ready;
    logic        busy;
    logic        prog_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    memoria_instrucciones_prog #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .FILL_WORD (FILL)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fetch_en      (fetch_en),
        .fetch_addr    (fetch_addr),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .prog_start    (prog_start),
        .prog_base     (prog_base),
        .prog_valid    (prog_valid),
        .prog_data     (prog_data),
        .prog_last     (prog_last),
        .prog_ready    (prog_ready),
        .busy          (busy),
        .prog_overflow (prog_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_CLEARING = 0;
    localparam int M_RUNNING  = 1;
    localparam int M_LOADING  = 2;

    logic [31:0] m_mem [int];
    int          m_mode       = M_CLEARING;
    int          m_clear_left = 0;
    int          m_wr         = 0;
    logic [31:0] m_instr      = FILL;
    bit          m_valid      = 1'b0;
    bit          m_ovf        = 1'b0;
    bit          m_seen       = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_seen       = 1'b1;
            m_mode       = M_CLEARING;
            m_clear_left = DEPTH;
            m_instr      = FILL;
            m_valid      = 1'b0;
            m_ovf        = 1'b0;
        end else if (m_seen) begin
            case (m_mode)
                M_CLEARING: begin
                    m_mem[DEPTH - m_clear_left] = FILL;
                    m_clear_left--;
                    if (m_clear_left == 0) m_mode = M_RUNNING;
                end
                M_RUNNING: begin
                    if (prog_start) begin
                        m_wr    = int'(prog_base) % DEPTH;
                        m_ovf   = 1'b0;
                        m_valid = 1'b0;
                        m_mode  = M_LOADING;
                    end else if (fetch_en) begin
                        m_instr = (int'(fetch_addr) < DEPTH) ? m_mem[int'(fetch_addr)] : FILL;
                        m_valid = 1'b1;
                    end
                end
                default: begin
                    if (prog_start) begin
                        m_wr  = int'(prog_base) % DEPTH;
                        m_ovf = 1'b0;
                    end else if (prog_valid) begin
                        m_mem[m_wr] = prog_data;
                        if (m_wr == DEPTH - 1) m_ovf = 1'b1;
                        m_wr = (m_wr + 1) % DEPTH;
                        if (prog_last) m_mode = M_RUNNING;
                    end
                end
            endcase
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (m_seen) begin
            check("instr",         instr,                m_instr);
            check("instr_valid",   32'(instr_valid),     32'(m_valid));
            check("busy",          32'(busy),            32'(m_mode != M_RUNNING));
            check("prog_ready",    32'(prog_ready),      32'(m_mode == M_LOADING));
            check("prog_overflow", 32'(prog_overflow),   32'(m_ovf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle();
        fetch_en   = 1'b0;
        prog_start = 1'b0;
        prog_valid = 1'b0;
        prog_last  = 1'b0;
    endtask

    // Counts busy cycles until the fill ends; bounded.
    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            cnt++;
            cyc();
        end
    endtask

    task automatic fetch_chk(input logic [4:0] a, input logic [31:0] exp, input string name);
        fetch_en   = 1'b1;
        fetch_addr = a;
        cyc();
        fetch_en   = 1'b0;
        check(name, instr, exp);
        check({name, "_valid"}, 32'(instr_valid), 32'd1);
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        prog_valid = 1'b1;
        prog_data  = d;
        prog_last  = last;
        cyc();
        prog_valid = 1'b0;
        prog_last  = 1'b0;
    endtask

    initial begin
        int bc;
        reset_n    = 1'b0;
        idle();
        fetch_addr = '0;
        prog_base  = '0;
        prog_data  = '0;

        // Reset 3 cycles, then the fill must keep busy high for DEPTH cycles.
        cyc(3);
        reset_n = 1'b1;
        count_busy(bc);
        check("clear_busy_cycles", 32'(bc), 32'd16);
        fetch_chk(5'd5, FILL, "fetch_after_clear");

        // Two-word program at base 0.
        prog_start = 1'b1;
        prog_base  = 5'd0;
        cyc();
        prog_start = 1'b0;
        check("prog_ready_after_start", 32'(prog_ready), 32'd1);
        beat(32'h3C02_80FF, 1'b0);
        beat(32'h0021_0820, 1'b1);
        check("busy_after_last", 32'(busy), 32'd0);
        fetch_chk(5'd0, 32'h3C02_80FF, "fetch_prog0");
        fetch_chk(5'd1, 32'h0021_0820, "fetch_prog1");

        // Stall: instr/instr_valid hold while fetch_addr toggles.
        for (int i = 0; i < 4; i++) begin
            fetch_addr = (i % 2 == 1) ? 5'd3 : 5'd2;
            cyc();
            check("stall_instr", instr, 32'h0021_0820);
            check("stall_valid", 32'(instr_valid), 32'd1);
        end

        // Wrap past DEPTH-1; a lone prog_last without valid is ignored.
        prog_start = 1'b1;
        prog_base  = 5'd15;
        cyc();
        prog_start = 1'b0;
        prog_last  = 1'b1;
        cyc();
        prog_last  = 1'b0;
        check("last_without_valid_busy", 32'(busy), 32'd1);
        beat(32'hAAAA_0001, 1'b0);
        beat(32'hBBBB_0002, 1'b0);
        beat(32'hCCCC_0003, 1'b1);
        check("overflow_set", 32'(prog_overflow), 32'd1);
        fetch_chk(5'd15, 32'hAAAA_0001, "wrap_mem15");
        fetch_chk(5'd0,  32'hBBBB_0002, "wrap_mem0");
        fetch_chk(5'd1,  32'hCCCC_0003, "wrap_mem1");

        // prog_start beats a same-cycle fetch; base 20 folds to 4.
        prog_start = 1'b1;
        prog_base  = 5'd20;
        fetch_en   = 1'b1;
        fetch_addr = 5'd0;
        cyc();
        idle();
        check("overflow_cleared", 32'(prog_overflow), 32'd0);
        check("fetch_dropped_valid", 32'(instr_valid), 32'd0);
        check("fetch_dropped_instr", instr, 32'hCCCC_0003);
        beat(32'h1234_5678, 1'b0);
        // Re-latch in PROG: the offered word is not written.
        prog_start = 1'b1;
        prog_base  = 5'd9;
        prog_valid = 1'b1;
        prog_data  = 32'hDEAD_BEEF;
        cyc();
        idle();
        beat(32'h9999_0009, 1'b1);
        fetch_chk(5'd4, 32'h1234_5678, "base_mod_mem4");
        fetch_chk(5'd5, FILL,          "relatch_no_write");
        fetch_chk(5'd9, 32'h9999_0009, "relatch_mem9");

        // Out-of-range fetches return the fill word.
        fetch_chk(5'd20, FILL, "oob_20");
        fetch_chk(5'd31, FILL, "oob_31");

        // Reset in the middle of a 4-beat program.
        prog_start = 1'b1;
        prog_base  = 5'd6;
        cyc();
        prog_start = 1'b0;
        beat(32'h0606_0606, 1'b0);
        beat(32'h0707_0707, 1'b0);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        count_busy(bc);
        check("reclear_busy_cycles", 32'(bc), 32'd16);
        fetch_chk(5'd6, FILL, "reclear_mem6");
        fetch_chk(5'd7, FILL, "reclear_mem7");
        fetch_chk(5'd0, FILL, "reclear_mem0");

        // Randomized traffic, checked by the per-cycle compare.
        for (int c = 0; c < 3000; c++) begin
            reset_n    = ($urandom_range(0, 399) != 0);
            fetch_en   = 1'($urandom_range(0, 1));
            fetch_addr = 5'($urandom_range(0, 31));
            prog_start = ($urandom_range(0, 15) == 0);
            prog_base  = 5'($urandom);
            prog_valid = ($urandom_range(0, 2) != 0);
            prog_data  = $urandom;
            prog_last  = ($urandom_range(0, 5) == 0);
            cyc();
        end
        reset_n = 1'b1;
        idle();
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
